// File: rtl/fcp_pkg.sv
// Shared FCP definitions: framer state encoding, CRC polynomial and default
// payload-length width used by the transmit framer and its CRC engine sibling.
package fcp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    CSEND = 2'd3
  } fcp_state_e;

  localparam logic [7:0] CRC_POLY  = 8'h39;
  localparam int         FCP_LEN_W = 4;

endpackage

// File: rtl/fcp_txfrm.sv
// FCP transmit framer: moves payload bytes from the source to the serializer
// one at a time, steering the external CRC-8 engine, then appends its result.
module fcp_txfrm
  import fcp_pkg::*;
#(
  parameter int LEN_W = FCP_LEN_W
) (
  input  logic             clk,
  input  logic             srstz,
  input  logic             tx_start,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             tx_abort,
  input  logic             src_vld,
  input  logic [7:0]       src_dat,
  output logic             src_rdy,
  output logic             ser_vld,
  output logic [7:0]       ser_dat,
  output logic             ser_last,
  input  logic             ser_rdy,
  output logic             crc_en,
  output logic [7:0]       crc_din,
  output logic             crc_shfi,
  output logic             crc_shfl,
  input  logic [7:0]       tx_crc,
  output logic             busy,
  output logic             done,
  output logic             err
);

  fcp_state_e       state, state_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic [7:0]       dat_r, dat_nxt;
  logic             done_r, done_nxt;
  logic             err_r, err_nxt;
  logic             ser_hs;
  logic             last_byte;

  always_ff @(posedge clk) begin
    if (!srstz) begin
      state  <= IDLE;
      rem    <= '0;
      dat_r  <= 8'h00;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      dat_r  <= dat_nxt;
      done_r <= done_nxt;
      err_r  <= err_nxt;
    end
  end

  assign ser_hs    = ser_rdy && !tx_abort;
  assign last_byte = (rem == LEN_W'(1));

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    dat_nxt   = dat_r;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    src_rdy   = 1'b0;
    ser_vld   = 1'b0;
    ser_dat   = dat_r;
    ser_last  = 1'b0;
    crc_shfi  = 1'b0;
    crc_shfl  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          if (tx_len == '0) begin
            err_nxt = 1'b1;
          end else begin
            rem_nxt   = tx_len;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        src_rdy = 1'b1;
        if (tx_abort) begin
          state_nxt = IDLE;
        end else if (src_vld) begin
          dat_nxt   = src_dat;
          state_nxt = SEND;
        end
      end
      SEND: begin
        ser_vld = 1'b1;
        if (tx_abort) begin
          state_nxt = IDLE;
        end else if (ser_hs) begin
          // Engine absorbs the byte on the same edge the serializer takes it.
          rem_nxt   = rem - LEN_W'(1);
          crc_shfi  = !last_byte;
          crc_shfl  = last_byte;
          state_nxt = last_byte ? CSEND : LOAD;
        end
      end
      CSEND: begin
        ser_vld  = 1'b1;
        ser_dat  = tx_crc;
        ser_last = 1'b1;
        if (tx_abort) begin
          state_nxt = IDLE;
        end else if (ser_hs) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Engine is held clear whenever the framer is idle, so each frame starts at 0x00.
  assign busy    = (state != IDLE);
  assign crc_en  = busy;
  assign crc_din = dat_r;
  assign done    = done_r;
  assign err     = err_r;

endmodule

// File: tb/tb_fcp_txfrm.sv
// Directed bench for fcp_txfrm with a behavioural CRC-8 engine (poly 0x39,
// zero-byte augmented) wired to the framer's enable/data/shift pulses.
module tb_fcp_txfrm;

  logic       clk = 1'b0;
  logic       srstz;
  logic       tx_start;
  logic [3:0] tx_len;
  logic       tx_abort;
  logic       src_vld;
  logic [7:0] src_dat;
  logic       src_rdy;
  logic       ser_vld;
  logic [7:0] ser_dat;
  logic       ser_last;
  logic       ser_rdy;
  logic       crc_en;
  logic [7:0] crc_din;
  logic       crc_shfi;
  logic       crc_shfl;
  logic [7:0] tx_crc;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [8:0] got_q[$];
  int         n_shfi;
  int         n_shfl;
  logic [7:0] eng = 8'h00;

  fcp_txfrm #(.LEN_W(4)) dut (
    .clk(clk), .srstz(srstz), .tx_start(tx_start), .tx_len(tx_len),
    .tx_abort(tx_abort), .src_vld(src_vld), .src_dat(src_dat),
    .src_rdy(src_rdy), .ser_vld(ser_vld), .ser_dat(ser_dat),
    .ser_last(ser_last), .ser_rdy(ser_rdy), .crc_en(crc_en),
    .crc_din(crc_din), .crc_shfi(crc_shfi), .crc_shfl(crc_shfl),
    .tx_crc(tx_crc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] step8(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int k = 7; k >= 0; k--) begin
      fb = c[7];
      c  = {c[6:0], d[k]};
      if (fb) c = c ^ 8'h39;
    end
    return c;
  endfunction

  function automatic logic [7:0] crc_ref(input logic [7:0] b[16], input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) c = step8(c, b[i]);
    return step8(c, 8'h00);
  endfunction

  // CRC engine sibling: clears while disabled, shifts on the framer's pulses.
  always @(posedge clk) begin
    if (!crc_en)       eng <= 8'h00;
    else if (crc_shfl) eng <= step8(step8(eng, crc_din), 8'h00);
    else if (crc_shfi) eng <= step8(eng, crc_din);
  end
  assign tx_crc = eng;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int len, input logic [7:0] b[16], input int mode,
                           input bit poke, output int cycles);
    int         idx;
    bit         fin;
    bit         stalled;
    logic [7:0] hold_dat;
    got_q.delete();
    n_shfi   = 0;
    n_shfl   = 0;
    idx      = 0;
    fin      = 0;
    stalled  = 0;
    hold_dat = 8'h00;
    tx_start = 1'b1;
    tx_len   = 4'(len);
    tick();
    tx_start = 1'b0;
    cycles   = 1;
    while (cycles < 200 && !fin) begin
      if (done) begin
        fin = 1;
      end else begin
        src_vld  = (mode == 0) ? 1'b1 : ((cycles % 3) != 0);
        ser_rdy  = (mode == 0) ? 1'b1 : ((cycles % 4) != 1);
        src_dat  = src_vld ? b[idx] : ~b[idx];
        tx_start = poke && (cycles == 2);
        #1;
        if (stalled && ser_vld) chk("ser_stall_hold", ser_dat, hold_dat);
        stalled  = ser_vld && !ser_rdy;
        hold_dat = ser_dat;
        if (src_rdy && src_vld && idx < 15) idx++;
        if (ser_vld && ser_rdy) got_q.push_back({ser_last, ser_dat});
        if (crc_shfi) n_shfi++;
        if (crc_shfl) n_shfl++;
        tick();
        tx_start = 1'b0;
        cycles++;
      end
    end
    src_vld = 1'b0;
    ser_rdy = 1'b0;
    if (!fin) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_frame(input int len, input logic [7:0] b[16], input logic [7:0] exp_crc);
    chk("frame_bytes", got_q.size(), len + 1);
    if (got_q.size() == len + 1) begin
      for (int i = 0; i < len; i++) chk("payload_byte", got_q[i], {1'b0, b[i]});
      chk("crc_byte", got_q[len], {1'b1, exp_crc});
    end
    chk("n_shfi", n_shfi, len - 1);
    chk("n_shfl", n_shfl, 1);
  endtask

  initial begin
    logic [7:0] b1 [16];
    logic [7:0] b2 [16];
    logic [7:0] b15[16];
    int         cyc;

    b1  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b2  = '{8'h01, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    b15 = '{8'h10, 8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h42,
            8'h99, 8'h01, 8'hC3, 8'h5A, 8'hE7, 8'h24, 8'h6B, 8'h00};

    srstz = 1'b0; tx_start = 1'b0; tx_len = 4'd0; tx_abort = 1'b0;
    src_vld = 1'b0; src_dat = 8'h00; ser_rdy = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        {src_rdy, ser_vld, ser_dat, ser_last, crc_en, crc_din, crc_shfi, crc_shfl, busy, done, err},
        '0);
    srstz = 1'b1;
    tick();

    // Single-byte frame: 0x01 -> CRC 0x39, done in cycle 4.
    run_frame(1, b1, 0, 1'b0, cyc);
    check_frame(1, b1, 8'h39);
    chk("len1_done_cycle", cyc, 4);
    tick();

    // Two-byte frame {0x01,0x00} -> CRC 0x9C.
    run_frame(2, b2, 0, 1'b0, cyc);
    check_frame(2, b2, 8'h9C);
    chk("len2_done_cycle", cyc, 6);
    tick();

    // Fifteen bytes with source and serializer stalls.
    run_frame(15, b15, 1, 1'b0, cyc);
    check_frame(15, b15, crc_ref(b15, 15));
    tick();

    // Zero-length start.
    tx_start = 1'b1; tx_len = 4'd0;
    tick();
    tx_start = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("err_busy", busy, 1'b0);
    tick();
    chk("err_clears", err, 1'b0);
    chk("err_busy_after", busy, 1'b0);

    // tx_start while busy is ignored.
    run_frame(2, b2, 0, 1'b1, cyc);
    check_frame(2, b2, 8'h9C);
    tick();

    // Abort in SEND with a simultaneous serializer handshake.
    tx_start = 1'b1; tx_len = 4'd3;
    tick();
    tx_start = 1'b0; src_vld = 1'b1; src_dat = 8'h55;
    tick();
    src_vld = 1'b0; ser_rdy = 1'b1; tx_abort = 1'b1;
    #1;
    chk("abort_send_shfi", {crc_shfi, crc_shfl}, 2'b00);
    tick();
    tx_abort = 1'b0; ser_rdy = 1'b0;
    chk("abort_send_idle", {busy, crc_en, ser_vld, src_rdy}, 4'b0000);
    tick();
    chk("abort_send_nodone", done, 1'b0);

    // Abort in CSEND while the serializer is ready.
    tx_start = 1'b1; tx_len = 4'd1;
    tick();
    tx_start = 1'b0; src_vld = 1'b1; src_dat = 8'h01;
    tick();
    src_vld = 1'b0; ser_rdy = 1'b1;
    tick();
    chk("csend_crc", {ser_vld, ser_last, ser_dat}, {2'b11, 8'h39});
    tx_abort = 1'b1;
    tick();
    tx_abort = 1'b0; ser_rdy = 1'b0;
    chk("abort_csend_idle", {busy, crc_en, ser_vld, ser_last}, 4'b0000);
    chk("abort_csend_nodone", done, 1'b0);
    tick();
    chk("abort_csend_nodone2", done, 1'b0);

    run_frame(1, b1, 0, 1'b0, cyc);
    check_frame(1, b1, 8'h39);

    // Back-to-back: next start issued in the done cycle.
    run_frame(2, b2, 0, 1'b0, cyc);
    check_frame(2, b2, 8'h9C);
    chk("b2b_done_cycle", cyc, 6);
    tick();

    // Reset mid-frame.
    tx_start = 1'b1; tx_len = 4'd3;
    tick();
    tx_start = 1'b0; src_vld = 1'b1; src_dat = 8'hAA;
    tick();
    src_vld = 1'b0; srstz = 1'b0;
    tick();
    chk("midreset_outputs",
        {src_rdy, ser_vld, ser_dat, ser_last, crc_en, crc_din, crc_shfi, crc_shfl, busy, done, err},
        '0);
    srstz = 1'b1;
    tick();

    run_frame(1, b1, 0, 1'b0, cyc);
    check_frame(1, b1, 8'h39);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fcp_txfrm.md
# fcp_txfrm

FCP transmit framer: fetches a packet's payload bytes from a byte source, hands them one at a time to the downstream byte serializer, and appends the CRC-8 byte as the final byte. It sits directly upstream of the FCP CRC-8 engine (poly 0x39, init 0x00, zero-byte augmented), a sibling instance wired by the parent. The framer drives the engine's enable, data and shift pulses, then reads back the finished CRC.

## Interface
- LEN_W, 4: width of the payload length; max payload is 2^LEN_W-1 bytes.

- clk  in  1  sole clock
- srstz  in  1  reset, synchronous, active-low
- tx_start  in  1  start pulse; honoured only in IDLE
- tx_len  in  LEN_W  payload byte count, sampled with accepted tx_start
- tx_abort  in  1  abandon the current frame
- src_vld  in  1  payload byte available
- src_dat  in  8  payload byte
- src_rdy  out  1  framer accepts src_dat
- ser_vld  out  1  byte offered to serializer
- ser_dat  out  8  byte offered
- ser_last  out  1  marks the CRC byte, the frame's final byte
- ser_rdy  in  1  serializer accepts ser_dat
- crc_en  out  1  CRC engine enable; low clears the engine
- crc_din  out  8  byte into CRC engine
- crc_shfi  out  1  shift-in pulse, non-last payload byte
- crc_shfl  out  1  shift-in pulse, last payload byte
- tx_crc  in  8  CRC engine result
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the CRC byte is accepted
- err  out  1  one-cycle pulse when tx_start arrives with tx_len == 0

## Operation
- States: IDLE, LOAD, SEND, CSEND.
- **IDLE**
  - crc_en=0, so the CRC engine clears on every IDLE edge.
  - tx_start with tx_len != 0: rem <= tx_len, go to LOAD.
  - tx_start with tx_len == 0: err pulse, stay in IDLE.
- **LOAD**
  - src_rdy=1.
  - On src_vld: dat_r <= src_dat, go to SEND.
- **SEND**
  - ser_vld=1, ser_dat=dat_r.
  - On ser_rdy: rem <= rem-1, and
    - rem != 1: crc_shfi=1, go to LOAD.
    - rem == 1: crc_shfl=1, go to CSEND.
- **CSEND**
  - ser_vld=1, ser_dat=tx_crc, ser_last=1.
  - On ser_rdy: done next cycle, go to IDLE.
- crc_din = dat_r at all times.
- crc_shfi and crc_shfl are combinational and coincide with the payload handshake edge, so the engine absorbs the byte on the same edge the serializer takes it.
- crc_en = busy.
- rem is LEN_W bits. It never wraps, because it is loaded nonzero and leaves SEND at 1.
- tx_abort, any non-IDLE state: go to IDLE next edge, no done.
  - Drops ser_vld/src_rdy and clears the engine via crc_en=0.
  - tx_abort has priority over any handshake in the same cycle; that cycle's crc_shfi/crc_shfl are suppressed.
- tx_start while busy is ignored.
- srstz low: state IDLE, rem=0, dat_r=0x00. All outputs 0, including done and err.

## Timing
- Accepted tx_start at edge N: LOAD (src_rdy=1) in cycle N+1.
- Byte accepted from the source at edge M: ser_vld from cycle M+1.
- Best-case throughput: 2 cycles per payload byte, plus 1 cycle for the CRC byte.
- Minimum frame, n-byte payload, all handshakes immediate: 2n+2 cycles start→done.
- The last-byte handshake edge updates the engine with data plus zero augmentation. tx_crc is final in the first CSEND cycle and held stable, since no shift pulses occur in CSEND.
- done pulse lands in the IDLE cycle. A tx_start in that cycle is accepted, and crc_en=0 there guarantees the engine starts the next frame at 0x00.
- ser_dat/ser_vld stay stable while ser_vld=1 and ser_rdy=0.
- src_dat is ignored outside LOAD.

## Structure
- Shared package fcp_pkg:
  - state enum (IDLE/LOAD/SEND/CSEND)
  - CRC_POLY = 8'h39
  - FCP_LEN_W default
- No sub-module; the CRC engine is instantiated beside this block by the parent.
- Single always block for state/rem/dat_r, plus combinational outputs.

## Test plan
- tx_len=1, payload 0x01, ready always high → serializer sees 0x01 then 0x39 with ser_last; one crc_shfl, no crc_shfi; done at cycle 4.
- tx_len=2, payload {0x01,0x00} → serializer sees 0x01, 0x00, 0x9C; crc_shfi on byte 0, crc_shfl on byte 1.
- Random stalls on src_vld and ser_rdy, tx_len=15 → byte order preserved, ser_dat stable under stall, CRC matches model.
- tx_abort in SEND and in CSEND → IDLE next cycle, no done, crc_en low. Next frame of {0x01} again yields 0x39.
- tx_len=0 → err pulse, busy stays 0. tx_start while busy → ignored, frame unchanged.
- srstz low mid-frame → all outputs 0 next cycle; tx_start in the done cycle → back-to-back frame correct.
